// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order pipeline writeback path and a long-latency unit.
//
// Long-latency results are queued in a small in-order FIFO. When the FIFO is
// full it owns the port and the pipeline is stalled. Otherwise the pipeline
// has priority and the FIFO drains on idle pipeline cycles. A 32-bit
// scoreboard tracks destinations with outstanding long-latency results.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pipe_valid_i      pipeline writeback request
//   pipe_rd_i         pipeline destination register
//   pipe_data_i       pipeline writeback data
//   pipe_stall_o      pipeline request refused this cycle (comb)
//   lu_issue_i        long-latency op issued this cycle
//   lu_issue_rd_i     destination of the issued op
//   lu_valid_i        long-latency result offered
//   lu_rd_i           long-latency result destination
//   lu_data_i         long-latency result data
//   lu_ready_o        FIFO can accept a result (comb)
//   rf_we_o           register-file write enable (registered)
//   rf_rd_o           register-file write address (registered)
//   rf_data_o         register-file write data (registered)
//   busy_o            scoreboard, bit r = result for xr outstanding (registered)
module wb_port_arbiter #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid_i,
  input  logic [4:0]        pipe_rd_i,
  input  logic [DWIDTH-1:0] pipe_data_i,
  output logic              pipe_stall_o,
  input  logic              lu_issue_i,
  input  logic [4:0]        lu_issue_rd_i,
  input  logic              lu_valid_i,
  input  logic [4:0]        lu_rd_i,
  input  logic [DWIDTH-1:0] lu_data_i,
  output logic              lu_ready_o,
  output logic              rf_we_o,
  output logic [4:0]        rf_rd_o,
  output logic [DWIDTH-1:0] rf_data_o,
  output logic [31:0]       busy_o
);

  localparam int unsigned RW    = 5;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // One buffered long-latency result.
  typedef struct packed {
    logic [RW-1:0]     rd;
    logic [DWIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t         fifo_mem [DEPTH];
  wb_entry_t         head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              nonempty;
  logic              push;
  logic              grant_fifo;
  logic              grant_pipe;
  logic [RW-1:0]     gnt_rd;
  logic [DWIDTH-1:0] gnt_data;
  logic [31:0]       busy_nxt;

  assign head     = fifo_mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign nonempty = (count != '0);

  assign lu_ready_o   = (count < CNT_W'(DEPTH));
  assign pipe_stall_o = pipe_valid_i & full;
  assign push         = lu_valid_i & lu_ready_o;

  // Port arbitration on the registered occupancy: full FIFO first, then pipe.
  always_comb begin
    grant_fifo = 1'b0;
    grant_pipe = 1'b0;
    gnt_rd     = '0;
    gnt_data   = '0;
    if (full) begin
      grant_fifo = 1'b1;
    end else if (pipe_valid_i) begin
      grant_pipe = 1'b1;
    end else if (nonempty) begin
      grant_fifo = 1'b1;
    end
    if (grant_fifo) begin
      gnt_rd   = head.rd;
      gnt_data = head.data;
    end else if (grant_pipe) begin
      gnt_rd   = pipe_rd_i;
      gnt_data = pipe_data_i;
    end
  end

  // Scoreboard update: clear on FIFO grant, then set on issue so set wins.
  always_comb begin
    busy_nxt = busy_o;
    if (grant_fifo) begin
      busy_nxt[head.rd] = 1'b0;
    end
    if (lu_issue_i && (lu_issue_rd_i != '0)) begin
      busy_nxt[lu_issue_rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // FIFO storage; entries are invalidated by pointer/count reset, not cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{rd: lu_rd_i, data: lu_data_i};
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (grant_fifo) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, grant_fifo})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; address/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_o   <= 1'b0;
      rf_rd_o   <= '0;
      rf_data_o <= '0;
      busy_o    <= '0;
    end else begin
      rf_we_o <= (grant_fifo | grant_pipe) & (gnt_rd != '0);
      if (grant_fifo | grant_pipe) begin
        rf_rd_o   <= gnt_rd;
        rf_data_o <= gnt_data;
      end
      busy_o <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_valid_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        pipe_stall_o;
  logic        lu_issue_i;
  logic [4:0]  lu_issue_rd_i;
  logic        lu_valid_i;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic [31:0] busy_o;

  int n_cmp;
  int n_err;

  wb_port_arbiter #(.DWIDTH(32), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_valid_i (pipe_valid_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_data_i  (pipe_data_i),
    .pipe_stall_o (pipe_stall_o),
    .lu_issue_i   (lu_issue_i),
    .lu_issue_rd_i(lu_issue_rd_i),
    .lu_valid_i   (lu_valid_i),
    .lu_rd_i      (lu_rd_i),
    .lu_data_i    (lu_data_i),
    .lu_ready_o   (lu_ready_o),
    .rf_we_o      (rf_we_o),
    .rf_rd_o      (rf_rd_o),
    .rf_data_o    (rf_data_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid_i  = 1'b0;
    pipe_rd_i     = '0;
    pipe_data_i   = '0;
    lu_issue_i    = 1'b0;
    lu_issue_rd_i = '0;
    lu_valid_i    = 1'b0;
    lu_rd_i       = '0;
    lu_data_i     = '0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] data);
    pipe_valid_i = 1'b1;
    pipe_rd_i    = rd;
    pipe_data_i  = data;
  endtask

  task automatic lu_ret(input logic [4:0] rd, input logic [31:0] data);
    lu_valid_i = 1'b1;
    lu_rd_i    = rd;
    lu_data_i  = data;
  endtask

  task automatic issue(input logic [4:0] rd);
    lu_issue_i    = 1'b1;
    lu_issue_rd_i = rd;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, "_we"}, 32'(rf_we_o), 32'd1);
    check({tag, "_rd"}, 32'(rf_rd_o), 32'(rd));
    check({tag, "_data"}, rf_data_o, data);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    check("rst_we", 32'(rf_we_o), 32'd0);
    check("rst_rd", 32'(rf_rd_o), 32'd0);
    check("rst_data", rf_data_o, 32'd0);
    check("rst_busy", busy_o, 32'd0);
    check("rst_ready", 32'(lu_ready_o), 32'd1);
    reset = 1'b0;

    // Pipe only: one-cycle latency, never stalled.
    pipe(5'd5, 32'h0000_00AA);
    #1;
    check("pipe_stall", 32'(pipe_stall_o), 32'd0);
    tick();
    idle();
    check_wr("pipe", 5'd5, 32'h0000_00AA);
    tick();
    check("pipe_done_we", 32'(rf_we_o), 32'd0);
    check("pipe_hold_rd", 32'(rf_rd_o), 32'd5);

    // Load return with idle pipe: push, grant, register.
    issue(5'd7);
    tick();
    idle();
    check("ld_busy_set", busy_o, 32'h0000_0080);
    lu_ret(5'd7, 32'hDEAD_BEEF);
    tick();
    idle();
    check("ld_no_bypass", 32'(rf_we_o), 32'd0);
    tick();
    check_wr("ld", 5'd7, 32'hDEAD_BEEF);
    check("ld_busy_clr", busy_o, 32'd0);

    // Contention: pipe every cycle, two lu results fill the FIFO.
    pipe(5'd10, 32'h100);
    lu_ret(5'd3, 32'h33);
    tick();
    check_wr("ct_p0", 5'd10, 32'h100);
    pipe(5'd11, 32'h101);
    lu_ret(5'd4, 32'h44);
    tick();
    check_wr("ct_p1", 5'd11, 32'h101);
    lu_valid_i = 1'b0;
    pipe(5'd12, 32'h102);
    #1;
    check("ct_full_ready", 32'(lu_ready_o), 32'd0);
    check("ct_stall", 32'(pipe_stall_o), 32'd1);
    tick();
    check_wr("ct_f3", 5'd3, 32'h33);
    check("ct_unstall", 32'(pipe_stall_o), 32'd0);
    tick();
    idle();
    check_wr("ct_p2", 5'd12, 32'h102);
    tick();
    check_wr("ct_f4", 5'd4, 32'h44);
    tick();
    check("ct_drained", 32'(rf_we_o), 32'd0);
    check("ct_busy", busy_o, 32'd0);

    // x0: issue, return and pipe all target x0.
    issue(5'd0);
    pipe(5'd0, 32'h55);
    lu_ret(5'd0, 32'h66);
    tick();
    idle();
    check("x0_pipe_we", 32'(rf_we_o), 32'd0);
    check("x0_busy", busy_o, 32'd0);
    tick();
    check("x0_lu_we", 32'(rf_we_o), 32'd0);
    tick();
    check("x0_empty_we", 32'(rf_we_o), 32'd0);
    check("x0_ready", 32'(lu_ready_o), 32'd1);

    // Set/clear collision on x9: set wins.
    issue(5'd9);
    tick();
    idle();
    check("col_busy_set", busy_o, 32'h0000_0200);
    lu_ret(5'd9, 32'h99);
    tick();
    idle();
    issue(5'd9);
    tick();
    idle();
    check_wr("col", 5'd9, 32'h99);
    check("col_busy_kept", busy_o, 32'h0000_0200);
    lu_ret(5'd9, 32'h999);
    tick();
    idle();
    tick();
    check_wr("col2", 5'd9, 32'h999);
    check("col_busy_clr", busy_o, 32'd0);

    // Reset mid-operation with a full FIFO and busy = 0x18.
    issue(5'd3);
    tick();
    issue(5'd4);
    pipe(5'd20, 32'h200);
    lu_ret(5'd3, 32'h333);
    tick();
    lu_issue_i = 1'b0;
    pipe(5'd21, 32'h201);
    lu_ret(5'd4, 32'h444);
    tick();
    idle();
    check("mr_busy", busy_o, 32'h0000_0018);
    check("mr_full", 32'(lu_ready_o), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mr_we", 32'(rf_we_o), 32'd0);
    check("mr_rd", 32'(rf_rd_o), 32'd0);
    check("mr_data", rf_data_o, 32'd0);
    check("mr_busy0", busy_o, 32'd0);
    check("mr_ready", 32'(lu_ready_o), 32'd1);
    tick();
    check("mr_stale1", 32'(rf_we_o), 32'd0);
    tick();
    check("mr_stale2", 32'(rf_we_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
